gray_ptr_sync: RTL and testbench
================================

// Module: gray_ptr_sync
// PURPOSE
//  Parametrised multi-stage synchronizer for gray-coded ASYNC_FIFO pointers crossing into the clk domain.
//  Extends the plain 2-flop pointer sync with:
//   - configurable width and depth
//   - gray->binary output
//   - per-update change and wrap pulses
//   - a gray-code integrity monitor (sticky flag plus saturating violation counter)
//  Instanced once per direction in the ASYNC_FIFO: wr_ptr into rd domain, rd_ptr into wr domain.
// PARAMETERS
//  WIDTH     4  pointer width in bits, including the FIFO wrap MSB; legal >= 2
//  STAGES    2  synchronizer flop depth; legal >= 2
//  ERR_CNT_W 4  width of the saturating violation counter; legal >= 1
// PORTS
//  clk          in   1          destination-domain clock, rising edge
//  rst          in   1          asynchronous, active-low reset
//  pointer      in   WIDTH      gray pointer from source domain (asynchronous to clk)
//  err_clr      in   1          synchronous clear of gray_err and err_count
//  sync_gray    out  WIDTH      synchronized gray pointer (last stage)
//  sync_bin     out  WIDTH      binary equivalent of sync_gray (combinational decode of registers)
//  ptr_changed  out  1          high for each cycle in which sync_gray differs from its previous value
//  ptr_wrap     out  1          high when the sync_gray MSB toggled in this update
//  gray_err     out  1          sticky: an update changed more than one bit
//  err_count    out  ERR_CNT_W  saturating count of violating updates
// BEHAVIOUR
//  - Reset (rst=0, async): all stage flops, the prev register, gray_err and err_count go to 0.
//    Consequently sync_gray=0, sync_bin=0, ptr_changed=0, ptr_wrap=0.
//    Reset asserted mid-operation clears everything immediately.
//    The first post-reset edge does not produce a change pulse unless the pipeline data differs from 0.
//  - Chain: s[1] <= pointer; s[k] <= s[k-1] for k = 2..STAGES; sync_gray = s[STAGES].
//    Latency: a pointer value stable before edge n appears on sync_gray after edge n+STAGES-1 (STAGES cycles).
//  - No logic between pointer and s[1]; s[1..STAGES-1] feed only the next stage.
//  - sync_bin[WIDTH-1] = sync_gray[WIDTH-1]; sync_bin[i] = sync_bin[i+1] ^ sync_gray[i].
//  - prev <= sync_gray every edge; diff = sync_gray ^ prev (combinational).
//  - ptr_changed = |diff, valid in the same cycle sync_gray updates. Exactly one cycle per update.
//    Held pointer -> 0.
//  - ptr_wrap = diff[WIDTH-1]. For a full FIFO traversal this pulses once per wrap.
//  - Violation: popcount(diff) > 1 in a cycle. On the following edge:
//    - gray_err <= 1
//    - err_count <= err_count + 1, saturating at all-ones (never wraps to 0)
//  - err_clr=1 at an edge: gray_err <= 0, err_count <= 0.
//    If a violation occurs in the same cycle, set wins: gray_err=1, err_count=1.
//  - A violation still updates sync_gray/sync_bin with the sampled value; no filtering or hold.
//  - Monitor logic is observational only: no effect on the sync path.
// TESTING
//  1 Reset: rst=0 with pointer=4'b1010 -> all outputs 0.
//    Release rst, hold pointer -> sync_gray=1010 after 2 edges; ptr_changed=1 for 1 cycle; gray_err=0.
//  2 Latency: pointer 0000->0001 at edge n -> sync_gray=0001 after edge n+1.
//    ptr_changed=1 in that cycle only, sync_bin=0001.
//    With STAGES=3 the update arrives one edge later.
//  3 Gray count: drive 16 successive 4-bit gray codes, one every 3 cycles.
//    -> sync_bin follows 0..15 and wraps to 0; 16 ptr_changed pulses.
//    -> ptr_wrap on 0111->1000 binary (gray 0100->1100) and on 15->0.
//    -> gray_err=0 throughout.
//  4 Violation: pointer 0000->0011 -> gray_err=1 and err_count=1 one edge after sync_gray=0011.
//    17 violations with ERR_CNT_W=4 -> err_count saturates at 15.
//  5 Clear: err_clr=1 in the same cycle as a new violation -> gray_err=1, err_count=1.
//    err_clr alone -> both 0.
//  6 Reset mid-stream: rst pulsed low between clk edges while pointer toggles
//    -> all outputs 0 immediately, without waiting for an edge; chain refills in STAGES cycles.

Source files
------------

// File: rtl/gray_ptr_sync.sv
// gray_ptr_sync
// Multi-stage synchronizer for a gray-coded FIFO pointer entering the clk domain.
// Besides the plain flop chain it provides a binary decode of the synchronized
// pointer, per-update change/wrap pulses and a gray-code integrity monitor
// (sticky error flag plus saturating violation counter). The monitor only
// observes the synchronized value; it never alters the sync path.
module gray_ptr_sync #(
    parameter int WIDTH     = 4,
    parameter int STAGES    = 2,
    parameter int ERR_CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     pointer,
    input  logic                 err_clr,
    output logic [WIDTH-1:0]     sync_gray,
    output logic [WIDTH-1:0]     sync_bin,
    output logic                 ptr_changed,
    output logic                 ptr_wrap,
    output logic                 gray_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    // Element 0 is the first (metastability-catching) stage, element
    // STAGES-1 is the stage presented on sync_gray.
    logic [WIDTH-1:0]     stage_d [STAGES];
    logic [WIDTH-1:0]     stage_q [STAGES];

    logic [WIDTH-1:0]     prev_d;
    logic [WIDTH-1:0]     prev_q;
    logic [WIDTH-1:0]     diff;
    logic                 violation;

    logic                 gray_err_d;
    logic                 gray_err_q;
    logic [ERR_CNT_W-1:0] err_count_d;
    logic [ERR_CNT_W-1:0] err_count_q;

    // Chain inputs: raw pointer straight into the first stage, no logic in front of it.
    always_comb begin
        stage_d[0] = pointer;
        for (int k = 1; k < STAGES; k++) begin
            stage_d[k] = stage_q[k-1];
        end
    end

    // Synchronizer flops; the asynchronous reset empties the whole chain at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign sync_gray = stage_q[STAGES-1];

    // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
    always_comb begin
        sync_bin            = '0;
        sync_bin[WIDTH-1]   = sync_gray[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            sync_bin[i] = sync_bin[i+1] ^ sync_gray[i];
        end
    end

    // Bits that moved in the most recent update; more than one set bit means
    // the source pointer was not a legal single-step gray sequence.
    assign prev_d      = sync_gray;
    assign diff        = sync_gray ^ prev_q;
    assign ptr_changed = |diff;
    assign ptr_wrap    = diff[WIDTH-1];
    assign violation   = (diff & (diff - 1'b1)) != '0;

    // Monitor next state: a violation overrides a simultaneous clear, so the
    // counter restarts at one rather than zero in that case.
    always_comb begin
        gray_err_d  = gray_err_q;
        err_count_d = err_count_q;
        if (violation) begin
            gray_err_d = 1'b1;
            if (err_clr) begin
                err_count_d = ERR_CNT_W'(1);
            end else if (err_count_q != '1) begin
                err_count_d = err_count_q + 1'b1;
            end
        end else if (err_clr) begin
            gray_err_d  = 1'b0;
            err_count_d = '0;
        end
    end

    // Previous-value register and monitor state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q      <= '0;
            gray_err_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            prev_q      <= prev_d;
            gray_err_q  <= gray_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign gray_err  = gray_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Testbench for gray_ptr_sync: two instances (STAGES=2 and STAGES=3) share the
// same pointer stream. A history-of-samples model predicts every output each
// cycle; directed sections pin the model with literal expectations.
module tb_gray_ptr_sync;

    localparam int W  = 4;
    localparam int CW = 4;
    localparam logic [CW-1:0] CMAX = '1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst     = 1'b0;
    logic [W-1:0] pointer = '0;
    logic         err_clr = 1'b0;

    logic [W-1:0]  sg2, sb2, sg3, sb3;
    logic          ch2, wr2, ge2, ch3, wr3, ge3;
    logic [CW-1:0] ec2, ec3;

    gray_ptr_sync #(.WIDTH(W), .STAGES(2), .ERR_CNT_W(CW)) u_dut2 (
        .clk(clk), .rst(rst), .pointer(pointer), .err_clr(err_clr),
        .sync_gray(sg2), .sync_bin(sb2), .ptr_changed(ch2), .ptr_wrap(wr2),
        .gray_err(ge2), .err_count(ec2)
    );

    gray_ptr_sync #(.WIDTH(W), .STAGES(3), .ERR_CNT_W(CW)) u_dut3 (
        .clk(clk), .rst(rst), .pointer(pointer), .err_clr(err_clr),
        .sync_gray(sg3), .sync_bin(sb3), .ptr_changed(ch3), .ptr_wrap(wr3),
        .gray_err(ge3), .err_count(ec3)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // hq[0] is the pointer sampled at the latest edge; sync_gray of a
    // STAGES-deep synchronizer equals the sample taken STAGES-1 edges ago,
    // and its previous value is the sample STAGES edges ago. Samples from
    // before reset count as zero.
    logic [W-1:0]  hq[$];
    logic          m_err [2];
    logic [CW-1:0] m_cnt [2];

    function automatic int st(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic logic [W-1:0] samp(input int k);
        if (k < hq.size()) return hq[k];
        return '0;
    endfunction

    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = g;
        for (int s = 1; s < W; s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            hq.delete();
            for (int d = 0; d < 2; d++) begin
                m_err[d] = 1'b0;
                m_cnt[d] = '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                logic [W-1:0] df;
                df = samp(st(d) - 1) ^ samp(st(d));
                if ($countones(df) > 1) begin
                    m_err[d] = 1'b1;
                    if (err_clr) m_cnt[d] = CW'(1);
                    else if (m_cnt[d] != CMAX) m_cnt[d] = m_cnt[d] + 1'b1;
                end else if (err_clr) begin
                    m_err[d] = 1'b0;
                    m_cnt[d] = '0;
                end
            end
            hq.push_front(pointer);
            if (hq.size() > 8) void'(hq.pop_back());
        end
    end

    task automatic cmp_dut(input int d, input logic [W-1:0] sg, input logic [W-1:0] sb,
                           input logic ch, input logic wr, input logic ge,
                           input logic [CW-1:0] ec);
        logic [W-1:0] es, ep;
        es = samp(st(d) - 1);
        ep = samp(st(d));
        check($sformatf("S%0d sync_gray", st(d)), sg, es);
        check($sformatf("S%0d sync_bin", st(d)), sb, g2b(es));
        check($sformatf("S%0d ptr_changed", st(d)), ch, int'(es != ep));
        check($sformatf("S%0d ptr_wrap", st(d)), wr, int'(es[W-1] ^ ep[W-1]));
        check($sformatf("S%0d gray_err", st(d)), ge, m_err[d]);
        check($sformatf("S%0d err_count", st(d)), ec, m_cnt[d]);
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        cmp_dut(0, sg2, sb2, ch2, wr2, ge2, ec2);
        cmp_dut(1, sg3, sb3, ch3, wr3, ge3, ec3);
    end

    // ---------------- directed + random stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    int ch_cnt, wr_cnt, exp_bin, bc;
    logic [W-1:0] p_hold;

    initial begin
        // Reset with a non-zero pointer present
        rst = 1'b0;
        pointer = 4'b1010;
        tick(2);
        check("rst sync_gray", sg2, 0);
        check("rst sync_bin", sb2, 0);
        check("rst ptr_changed", ch2, 0);
        check("rst ptr_wrap", wr2, 0);
        check("rst gray_err", ge2, 0);
        check("rst err_count", ec2, 0);
        rst = 1'b1;
        tick(2);
        check("post-rst sync_gray", sg2, 4'b1010);
        check("post-rst sync_bin", sb2, 4'b1100);
        check("post-rst ptr_changed", ch2, 1);
        check("post-rst gray_err", ge2, 0);
        tick(1);
        check("post-rst changed drop", ch2, 0);
        check("post-rst 2-bit jump err", ge2, 1);
        check("post-rst 2-bit jump cnt", ec2, 1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("clr gray_err", ge2, 0);
        check("clr err_count", ec2, 0);

        // Back to zero and clean up the error it causes
        pointer = 4'b0000;
        tick(5);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        tick(1);

        // Latency
        pointer = 4'b0001;
        tick(1);
        check("lat S2 not yet", sg2, 0);
        tick(1);
        check("lat S2 sync_gray", sg2, 1);
        check("lat S2 changed", ch2, 1);
        check("lat S2 sync_bin", sb2, 1);
        check("lat S3 not yet", sg3, 0);
        tick(1);
        check("lat S2 changed drop", ch2, 0);
        check("lat S3 sync_gray", sg3, 1);
        check("lat S3 changed", ch3, 1);

        // Full gray count traversal
        pointer = 4'b0000;
        tick(4);
        ch_cnt = 0;
        wr_cnt = 0;
        exp_bin = 0;
        for (int i = 1; i <= 16; i++) begin
            pointer = b2g(W'(i));
            repeat (3) begin
                tick(1);
                ch_cnt += int'(ch2);
                wr_cnt += int'(wr2);
                if (ch2) begin
                    exp_bin = (exp_bin + 1) % 16;
                    check("count sync_bin step", sb2, exp_bin);
                end
            end
        end
        repeat (3) begin
            tick(1);
            ch_cnt += int'(ch2);
            wr_cnt += int'(wr2);
        end
        check("count ptr_changed pulses", ch_cnt, 16);
        check("count ptr_wrap pulses", wr_cnt, 2);
        check("count gray_err", ge2, 0);
        check("count final sync_bin", sb2, 0);

        // Violations and saturation
        pointer = 4'b0011;
        tick(2);
        check("viol sync_gray", sg2, 4'b0011);
        check("viol err not yet", ge2, 0);
        tick(1);
        check("viol gray_err", ge2, 1);
        check("viol err_count", ec2, 1);
        for (int j = 0; j < 16; j++) begin
            pointer = (j % 2 == 0) ? 4'b0000 : 4'b0011;
            tick(2);
        end
        tick(3);
        check("sat err_count", ec2, 15);
        check("sat gray_err", ge2, 1);

        // Clear alone
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("clr alone gray_err", ge2, 0);
        check("clr alone err_count", ec2, 0);

        // Clear coinciding with a violation: set wins
        pointer = 4'b0110;
        tick(2);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("clr+viol gray_err", ge2, 1);
        check("clr+viol err_count", ec2, 1);

        // Randomized stream: mostly gray increments, occasional illegal jumps
        bc = 0;
        repeat (300) begin
            if ($urandom_range(0, 5) == 0) begin
                pointer = W'($urandom);
            end else begin
                bc++;
                pointer = b2g(W'(bc));
            end
            err_clr = ($urandom_range(0, 7) == 0);
            tick($urandom_range(1, 3));
        end
        err_clr = 1'b0;

        // Reset mid-stream, between edges
        @(posedge clk);
        #2;
        pointer = W'($urandom);
        #1;
        rst = 1'b0;
        #1;
        check("mid-rst S2 sync_gray", sg2, 0);
        check("mid-rst S2 sync_bin", sb2, 0);
        check("mid-rst S2 changed", ch2, 0);
        check("mid-rst S2 gray_err", ge2, 0);
        check("mid-rst S2 err_count", ec2, 0);
        check("mid-rst S3 sync_gray", sg3, 0);
        check("mid-rst S3 err_count", ec3, 0);
        #2;
        rst = 1'b1;
        p_hold = W'($urandom_range(1, 15));
        pointer = p_hold;
        tick(2);
        check("refill S2 sync_gray", sg2, p_hold);
        tick(1);
        check("refill S3 sync_gray", sg3, p_hold);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
